// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start, 8 data bits LSB first, even-XOR parity, stop; majority-vote sampling.
// Latency: line-to-arm is 3 clk (2-flop sync + edge history); byte/flags register 1 clk after the stop-bit mid-sample tick.
// Backpressure: rx_valid holds until rx_valid && rx_ready; a new byte overwrites an unaccepted one and sets overrun_err.
//
// Ports:
//   clk, reset_n          system clock (rising edge), asynchronous active-low reset
//   baud_sel[1:0]         00=4800, 01=9600, 10=19200, 11=38400; latched when a start edge arms the receiver
//   rx_line               asynchronous serial input, idles high
//   rx_ready              consumer accepts rx_data when rx_valid && rx_ready
//   rx_data[7:0]          last received byte
//   rx_valid              byte available, held until accepted
//   parity_err            parity mismatch on the byte in rx_data
//   frame_err             stop bit sampled low on the byte in rx_data
//   overrun_err           previous byte was still unaccepted when this one landed
//   busy                  receiver is inside a frame
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] baud_sel,
    input  logic       rx_line,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    // Sample-tick divisors, one per baud rate.
    localparam int DIV_4800  = CLK_FREQ / (4800  * OVERSAMPLE);
    localparam int DIV_9600  = CLK_FREQ / (9600  * OVERSAMPLE);
    localparam int DIV_19200 = CLK_FREQ / (19200 * OVERSAMPLE);
    localparam int DIV_38400 = CLK_FREQ / (38400 * OVERSAMPLE);
    // The slowest rate has the largest divisor and sets the counter width.
    localparam int TW = (DIV_4800 > 1) ? $clog2(DIV_4800) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state;
    logic [1:0]      baud_lat;
    logic [TW-1:0]   tick_cnt;
    logic [TW-1:0]   div_m1;
    logic [3:0]      os_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bad;
    logic            samp_7;
    logic            samp_8;

    // Input synchronizer plus one history flop for falling-edge detection.
    logic            sync_meta;
    logic            sync_cur;
    logic            sync_prev;
    // Counts the cycles since reset release until sync_prev holds a real line
    // sample; the reset value of 1 in the flops must not look like an idle line.
    logic [1:0]      fill_cnt;

    logic            start_edge;
    logic            tick;
    logic            resolve;
    logic            bit_end;
    logic            maj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_cur  <= 1'b1;
            sync_prev <= 1'b1;
            fill_cnt  <= 2'd0;
        end else begin
            sync_meta <= rx_line;
            sync_cur  <= sync_meta;
            sync_prev <= sync_cur;
            if (fill_cnt != 2'd3) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
        end
    end

    // A low line present at reset release never arms: the edge needs a sampled high first.
    assign start_edge = (fill_cnt == 2'd3) && sync_prev && !sync_cur;

    always_comb begin
        div_m1 = TW'(DIV_9600 - 1);
        case (baud_lat)
            2'b00:   div_m1 = TW'(DIV_4800  - 1);
            2'b01:   div_m1 = TW'(DIV_9600  - 1);
            2'b10:   div_m1 = TW'(DIV_19200 - 1);
            default: div_m1 = TW'(DIV_38400 - 1);
        endcase
    end

    assign tick    = (state != S_IDLE) && (tick_cnt == div_m1);
    assign resolve = tick && (os_cnt == 4'd9);
    assign bit_end = tick && (os_cnt == 4'd15);
    // Third vote is the live sample taken on the resolving tick itself.
    assign maj     = (samp_7 & samp_8) | (samp_7 & sync_cur) | (samp_8 & sync_cur);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            baud_lat    <= 2'b00;
            tick_cnt    <= '0;
            os_cnt      <= 4'd0;
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            par_bad     <= 1'b0;
            samp_7      <= 1'b0;
            samp_8      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Acceptance drops valid; a same-cycle new byte below overrides this.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (state != S_IDLE) begin
                if (tick) begin
                    tick_cnt <= '0;
                    os_cnt   <= os_cnt + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
                if (tick && (os_cnt == 4'd7)) begin
                    samp_7 <= sync_cur;
                end
                if (tick && (os_cnt == 4'd8)) begin
                    samp_8 <= sync_cur;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        baud_lat <= baud_sel;
                        tick_cnt <= '0;
                        os_cnt   <= 4'd0;
                        bit_cnt  <= 3'd0;
                        state    <= S_START;
                        busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (resolve && maj) begin
                        // Glitch shorter than half a bit: drop back silently.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (resolve) begin
                        shift <= {maj, shift[7:1]};
                    end
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (resolve) begin
                        par_bad <= (maj != (^shift));
                    end
                    if (bit_end) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop so a following start edge is never missed.
                    if (resolve) begin
                        rx_data     <= shift;
                        parity_err  <= par_bad;
                        frame_err   <= !maj;
                        rx_valid    <= 1'b1;
                        overrun_err <= rx_valid && !rx_ready;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

    // Reduced clock so the sample divisors are 32/16/8/4 and a run stays short.
    localparam int CLK_FREQ = 2457600;

    logic       clk;
    logic       reset_n;
    logic [1:0] baud_sel;
    logic       rx_line;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ready_mode  = 1;   // 0: hold low, 1: hold high, 2: random per cycle
    bit   stalled     = 0;   // consumer is known not to accept during the next frames

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_sel    (baud_sel),
        .rx_line     (rx_line),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_clks(input logic [1:0] sel);
        return 16 * (CLK_FREQ / ((4800 << sel) * 16));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame yields its byte, parity error when the sent
    // parity was corrupted, frame error when the stop bit was low; if the
    // consumer is stalled the pending byte is replaced and flagged as overrun.
    task automatic push_exp(input logic [7:0] d, input logic bad_par, input logic stop_val);
        exp_t e;
        e.d = d;
        e.p = bad_par;
        e.f = ~stop_val;
        e.o = 1'b0;
        if (stalled && exp_q.size() > 0) begin
            e.o = 1'b1;
            exp_q[exp_q.size() - 1] = e;
        end else begin
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_val,
                              input logic [1:0] bsel, input bit scramble, input int gap);
        logic [10:0] bits;
        int bt;
        bt = bit_clks(bsel);
        bits = {stop_val, (^d) ^ bad_par, d, 1'b0};
        baud_sel = bsel;
        rx_line  = 1'b1;
        repeat (4) @(negedge clk);
        push_exp(d, bad_par, stop_val);
        for (int i = 0; i < 11; i++) begin
            rx_line = bits[i];
            if (i == 0 && scramble) begin
                // Change baud_sel after the start edge is taken; the frame must not notice.
                repeat (12) @(negedge clk);
                baud_sel = 2'($urandom);
                repeat (bt - 12) @(negedge clk);
            end else begin
                repeat (bt) @(negedge clk);
            end
        end
        rx_line = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Consumer ready driver.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted byte is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got data 0x%02h, expected no byte", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte{data,par,frm,ovr}",
                          32'({rx_data, parity_err, frame_err, overrun_err}), 32'(e));
                end
            end
        end
    end

    initial begin
        int bt;
        reset_n  = 1'b0;
        rx_line  = 1'b1;
        baud_sel = 2'b01;
        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({rx_data, rx_valid, parity_err, frame_err, overrun_err, busy}), 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        bt = bit_clks(2'b01);

        // Clean byte, then parity error, then framing error cleared by a good frame.
        ready_mode = 1;
        send_frame(8'hA5, 1'b0, 1'b1, 2'b01, 1'b0, 20);
        check("a5_valid_dropped", 32'(rx_valid), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b1, 2'b01, 1'b0, 20);
        send_frame(8'h81, 1'b0, 1'b0, 2'b01, 1'b0, 20);
        send_frame(8'h42, 1'b0, 1'b1, 2'b01, 1'b0, 20);

        // False start: three sample ticks low.
        repeat (4) @(negedge clk);
        rx_line = 1'b0;
        repeat (bt / 16 * 2) @(negedge clk);
        check("false_start_busy_high", 32'(busy), 32'h1);
        repeat (bt / 16) @(negedge clk);
        rx_line = 1'b1;
        repeat (bt / 16 * 12) @(negedge clk);
        check("false_start_busy_low", 32'(busy), 32'h0);
        check("false_start_no_valid", 32'(rx_valid), 32'h0);

        // Overrun: consumer stalled across two back-to-back frames.
        ready_mode = 0;
        repeat (3) @(negedge clk);
        stalled = 1;
        send_frame(8'h11, 1'b0, 1'b1, 2'b01, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 2'b01, 1'b0, 0);
        check("overrun_valid_held", 32'(rx_valid), 32'h1);
        check("overrun_data", 32'(rx_data), 32'h22);
        check("overrun_flag", 32'(overrun_err), 32'h1);
        stalled    = 0;
        ready_mode = 1;
        repeat (10) @(negedge clk);
        check("accept_valid_low", 32'(rx_valid), 32'h0);
        check("accept_data_hold", 32'(rx_data), 32'h22);
        check("accept_overrun_hold", 32'(overrun_err), 32'h1);

        // Reset in the middle of a 0x55 frame, released while the line is low.
        baud_sel = 2'b01;
        repeat (4) @(negedge clk);
        rx_line = 1'b0;
        repeat (bt) @(negedge clk);
        rx_line = 1'b1;
        repeat (bt) @(negedge clk);
        rx_line = 1'b0;
        repeat (bt / 2) @(negedge clk);
        check("mid_frame_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_frame_reset_outputs",
              32'({rx_data, rx_valid, parity_err, frame_err, overrun_err, busy}), 32'h0);
        reset_n = 1'b1;
        repeat (600) @(negedge clk);
        check("low_after_reset_not_armed", 32'({busy, rx_valid}), 32'h0);
        rx_line = 1'b1;
        repeat (2 * bt) @(negedge clk);
        send_frame(8'h66, 1'b0, 1'b1, 2'b01, 1'b0, 20);

        // Randomized frames at random rates with a randomly stalling consumer.
        ready_mode = 2;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic       bad;
            logic       stp;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            send_frame(d, bad, stp, 2'($urandom), 1'b1, int'($urandom_range(0, 30)));
        end
        ready_mode = 1;
        repeat (100) @(negedge clk);
        check("all_bytes_delivered", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
